// File: rtl/math_pkg.sv
// -----------------------------------------------------------------------------
// math_pkg
// Shared definitions for the math accumulation slice.
//   CNT_W   : width of the per-window sample counter (windows up to 255 samples)
//   state_t : window FSM states
//               IDLE  - no sample in the current window
//               ACCUM - 1..WIN-1 samples collected
//               HOLD  - result presented, waiting for downstream
// -----------------------------------------------------------------------------
package math_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : math_pkg

// File: rtl/math_sat_add.sv
// -----------------------------------------------------------------------------
// math_sat_add
// Combinational unsigned saturating adder: y = min(a + b, 2^W - 1).
// Ports:
//   a, b : W-bit unsigned addends
//   y    : W-bit clamped sum
//   sat  : 1 when the true sum did not fit and y was clamped
// -----------------------------------------------------------------------------
module math_sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         sat
);

  // One extra bit holds the carry that signals overflow.
  logic [W:0] sum;

  // NOTE: every variable is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    sat = sum[W];
    y   = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

endmodule : math_sat_add

// File: rtl/math_sum_acc.sv
// -----------------------------------------------------------------------------
// math_sum_acc
// Accumulates WIN unsigned samples from the upstream math stage into a
// saturating window total, then presents total, sample count and a sticky
// saturation flag until downstream takes them. A window can be closed early
// with flush; a flush that arrives together with a sample includes it.
//
// Parameters:
//   DATA_W : width of in_sum
//   WIN    : samples per window (2..255)
//   ACC_W  : accumulator width (ACC_W >= DATA_W)
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset, wins over everything
//   in_valid  : in_sum carries a sample
//   in_sum    : unsigned sample
//   in_ready  : a sample can be accepted this cycle
//   flush     : close the current window early
//   out_valid : out_acc/out_cnt/out_sat are valid
//   out_ready : downstream consumes the result
//   out_acc   : window total (saturating)
//   out_cnt   : samples in the window
//   out_sat   : saturation occurred in the window
// -----------------------------------------------------------------------------
module math_sum_acc
  import math_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sat;

  logic               accept;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   acc_nxt;
  logic               clamp;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               sat_nxt;
  logic               last;

  // Ready depends only on state; held low during reset so nothing is taken
  // while the block is being cleared.
  assign in_ready = (state != HOLD) && !rst;
  assign accept   = in_valid && in_ready;

  assign in_ext   = ACC_W'(in_sum);
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign sat_nxt  = sat || clamp;
  // WIN-th sample closes the window, so count never exceeds WIN.
  assign last     = (cnt_nxt == WIN_C);

  math_sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (in_ext),
    .y   (acc_nxt),
    .sat (clamp)
  );

  // NOTE: synchronous reset - rst is sampled only at the clock edge, and every register, including the result registers, is cleared.
  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            sat <= sat_nxt;
            if (last || flush) begin
              // Present the updated totals, including this sample.
              state     <= HOLD;
              out_valid <= 1'b1;
              out_acc   <= acc_nxt;
              out_cnt   <= cnt_nxt;
              out_sat   <= sat_nxt;
            end else begin
              state <= ACCUM;
            end
          end else if (flush && state == ACCUM) begin
            // Early close without a sample; a flush in IDLE is dropped so an
            // empty window is never emitted.
            state     <= HOLD;
            out_valid <= 1'b1;
            out_acc   <= acc;
            out_cnt   <= cnt;
            out_sat   <= sat;
          end
        end

        HOLD: begin
          // Flush and samples are ignored here; results stay frozen.
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : math_sum_acc
